// File: rtl/uart_rx_core.sv
// Inverted-polarity UART receiver (idle/stop = 0, start = 1), LSB first, one stop bit.
// Optional macro UART_RX_FRAME_ERR_EN adds a one-cycle frame_err strobe on a bad stop bit.
module uart_rx_core #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in,
  output logic                 ready,
  output logic [DATA_BITS-1:0] out
`ifdef UART_RX_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((H > 0) ? H - 1 : 0);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_ld;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg, sh_next;
  logic                 tick, last_bit;
  logic                 cnt_load, bit_clr, shift_en, done;
`ifdef UART_RX_FRAME_ERR_EN
  logic                 bad_stop;
`endif

  assign tick     = (cnt == '0);
  assign last_bit = (bitcnt == BW'(DATA_BITS - 1));

  if (DATA_BITS > 1) begin : g_sh
    assign sh_next = {in, shreg[DATA_BITS-1:1]};
  end else begin : g_sh1
    assign sh_next = in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in) state_n = (H > 0) ? START : DATA;
      START:   if (tick) state_n = in ? DATA : IDLE;
      DATA:    if (tick && last_bit) state_n = STOP;
      STOP:    if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counter is reloaded at each sampling edge and counts down to the next one.
  always_comb begin
    cnt_load = 1'b0;
    cnt_ld   = '0;
    bit_clr  = 1'b0;
    shift_en = 1'b0;
    done     = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    bad_stop = 1'b0;
`endif
    case (state)
      IDLE: if (in) begin
        cnt_load = 1'b1;
        cnt_ld   = (H > 0) ? CNT_HALF : CNT_BIT;
        bit_clr  = 1'b1;
      end
      START: if (tick && in) begin
        cnt_load = 1'b1;
        cnt_ld   = CNT_BIT;
      end
      DATA: if (tick) begin
        cnt_load = 1'b1;
        cnt_ld   = CNT_BIT;
        shift_en = 1'b1;
      end
      STOP: if (tick) begin
        done = ~in;
`ifdef UART_RX_FRAME_ERR_EN
        bad_stop = in;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      out    <= '0;
      ready  <= 1'b0;
    end else begin
      ready <= done;
      if (cnt_load)         cnt <= cnt_ld;
      else if (cnt != '0)   cnt <= cnt - CW'(1);
      if (bit_clr)          bitcnt <= '0;
      else if (shift_en)    bitcnt <= bitcnt + BW'(1);
      if (shift_en)         shreg <= sh_next;
      if (done)             out <= shreg;
    end
  end

`ifdef UART_RX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) frame_err <= 1'b0;
    else       frame_err <= bad_stop;
  end
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: default 1 clk/bit instance plus a 3 clk/bit, 4-bit instance
// for the start-glitch path. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       ser, ser2;
  logic       ready, ready2;
  logic [7:0] out;
  logic [3:0] out2;
`ifdef UART_RX_FRAME_ERR_EN
  logic       frame_err, frame_err2;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  uart_rx_core #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .reset(reset), .in(ser), .ready(ready), .out(out)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_err(frame_err)
`endif
  );

  uart_rx_core #(.DATA_BITS(4), .CLKS_PER_BIT(3)) dut2 (
    .clk(clk), .reset(reset), .in(ser2), .ready(ready2), .out(out2)
`ifdef UART_RX_FRAME_ERR_EN
    , .frame_err(frame_err2)
`endif
  );

  // bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop level
  function automatic logic [9:0] frame(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b1};
  endfunction

  task automatic test_reset;
    reset = 1'b1; ser = 1'bx; ser2 = 1'bx;
    repeat (2) @(negedge clk);
    total++;
    if ({ready, out} !== 9'h000) $display("FAIL reset: ready/out=%b/%h expected 0/00", ready, out);
    else passed++;
    total++;
    if ({ready2, out2} !== 5'h00) $display("FAIL reset2: ready2/out2=%b/%h expected 0/0", ready2, out2);
    else passed++;
  endtask

  task automatic test_idle;
    reset = 1'b0; ser = 1'b0; ser2 = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({ready, out} !== 9'h000) $display("FAIL idle: ready/out=%b/%h expected 0/00", ready, out);
    else passed++;
  endtask

  task automatic test_single_frame;
    logic [31:0] seq;
    seq = {22'b0, frame(8'hAC, 1'b0)};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (i == 10) begin
        if ({ready, out} !== {1'b1, 8'hAC}) $display("FAIL single_strobe: ready/out=%b/%h expected 1/ac", ready, out);
        else passed++;
      end else if (i == 11) begin
        if ({ready, out} !== {1'b0, 8'hAC}) $display("FAIL single_hold: ready/out=%b/%h expected 0/ac", ready, out);
        else passed++;
      end else begin
        if (ready !== 1'b0) $display("FAIL single_early i=%0d: ready=%b expected 0", i, ready);
        else passed++;
      end
      ser = seq[i];
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] seq;
    seq = {12'b0, frame(8'h4D, 1'b0), frame(8'h93, 1'b0)};
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 10) begin
        total++;
        if ({ready, out} !== {1'b1, 8'h93}) $display("FAIL b2b_first: ready/out=%b/%h expected 1/93", ready, out);
        else passed++;
      end else if (i > 10 && i < 20) begin
        total++;
        if ({ready, out} !== {1'b0, 8'h93}) $display("FAIL b2b_gap i=%0d: ready/out=%b/%h expected 0/93", i, ready, out);
        else passed++;
      end else if (i == 20) begin
        total++;
        if ({ready, out} !== {1'b1, 8'h4D}) $display("FAIL b2b_second: ready/out=%b/%h expected 1/4d", ready, out);
        else passed++;
      end else if (i == 21) begin
        total++;
        if ({ready, out} !== {1'b0, 8'h4D}) $display("FAIL b2b_drop: ready/out=%b/%h expected 0/4d", ready, out);
        else passed++;
      end
      ser = seq[i];
    end
  endtask

  task automatic test_frame_error;
    logic [31:0] seq;
    seq = {11'b0, frame(8'h3C, 1'b0), 1'b0, frame(8'h5A, 1'b1)};
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      total++;
      if (i <= 20) begin
        if ({ready, out} !== {1'b0, 8'h4D}) $display("FAIL ferr_hold i=%0d: ready/out=%b/%h expected 0/4d", i, ready, out);
        else passed++;
      end else if (i == 21) begin
        if ({ready, out} !== {1'b1, 8'h3C}) $display("FAIL ferr_recover: ready/out=%b/%h expected 1/3c", ready, out);
        else passed++;
      end else begin
        if ({ready, out} !== {1'b0, 8'h3C}) $display("FAIL ferr_recover_drop: ready/out=%b/%h expected 0/3c", ready, out);
        else passed++;
      end
`ifdef UART_RX_FRAME_ERR_EN
      total++;
      if (frame_err !== (i == 10)) $display("FAIL frame_err i=%0d: got %b expected %b", i, frame_err, (i == 10));
      else passed++;
`endif
      ser = seq[i];
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] seq;
    seq = {22'b0, frame(8'hE7, 1'b0)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ser = seq[i];
    end
    @(negedge clk);
    reset = 1'b1; ser = 1'bx;
    #1;
    total++;
    if ({ready, out} !== 9'h000) $display("FAIL midreset_async: ready/out=%b/%h expected 0/00", ready, out);
    else passed++;
    @(negedge clk);
    total++;
    if ({ready, out} !== 9'h000) $display("FAIL midreset_hold: ready/out=%b/%h expected 0/00", ready, out);
    else passed++;
    reset = 1'b0; ser = 1'b0;
    seq = {22'b0, frame(8'hFF, 1'b0)};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      total++;
      if (i == 10) begin
        if ({ready, out} !== {1'b1, 8'hFF}) $display("FAIL midreset_next: ready/out=%b/%h expected 1/ff", ready, out);
        else passed++;
      end else if (i == 11) begin
        if ({ready, out} !== {1'b0, 8'hFF}) $display("FAIL midreset_next_drop: ready/out=%b/%h expected 0/ff", ready, out);
        else passed++;
      end else begin
        if ({ready, out} !== 9'h000) $display("FAIL midreset_pre i=%0d: ready/out=%b/%h expected 0/00", i, ready, out);
        else passed++;
      end
      ser = seq[i];
    end
  endtask

  // 3 clk/bit: start confirm at S+1, data at S+4,7,10,13, stop at S+16
  task automatic test_slow_glitch_and_frame;
    logic [31:0] seq;
    seq = 32'h0000_0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        total++;
        if ({ready2, out2} !== 5'h00) $display("FAIL glitch i=%0d: ready2/out2=%b/%h expected 0/0", i, ready2, out2);
        else passed++;
      end
      ser2 = seq[i];
    end
    seq = 32'h0000_381F;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i == 17) begin
        total++;
        if ({ready2, out2} !== {1'b1, 4'h9}) $display("FAIL slow_frame: ready2/out2=%b/%h expected 1/9", ready2, out2);
        else passed++;
      end else if (i == 18) begin
        total++;
        if ({ready2, out2} !== {1'b0, 4'h9}) $display("FAIL slow_frame_drop: ready2/out2=%b/%h expected 0/9", ready2, out2);
        else passed++;
      end else if (i > 0) begin
        total++;
        if (ready2 !== 1'b0) $display("FAIL slow_early i=%0d: ready2=%b expected 0", i, ready2);
        else passed++;
      end
      ser2 = seq[i];
    end
  endtask

  initial begin
    test_reset;
    test_idle;
    test_single_frame;
    test_back_to_back;
    test_frame_error;
    test_reset_mid_frame;
    test_slow_glitch_and_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
